// File: rtl/imem_controller.sv
// imem_controller: word-addressed instruction memory for the fetch stage.
//
// A request is accepted in StIdle or StResp and answered with a one-cycle
// valid_o strobe LATENCY edges later, counting the accepting edge as the
// first. Writes commit byte lanes at the accepting edge and still produce a
// response; reads update instruction_o on the edge that enters StResp.
// Requests seen while in StWait are dropped, never queued.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset (memory array is not cleared)
//   request_i      access request from fetch
//   we_re_i        1 = write, 0 = read
//   mask_i         byte-lane enables for writes, bit i = byte i
//   address_i      byte address; bits above ADDR_W+1 ignored (space wraps)
//   wdata_i        write data
//   instruction_o  registered read data, held until the next read response
//   valid_o        one-cycle response strobe
//   fault_o        misaligned-access flag, only with IMEM_MISALIGN_CHECK_EN
//
// Optional feature macro: IMEM_MISALIGN_CHECK_EN. When defined, an accepted
// access with address_i[1:0] != 0 responds with fault_o=1, reads return a NOP
// and writes are suppressed. When undefined, fault_o is tied low and the low
// address bits are ignored.

module imem_controller #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        request_i,
  input  logic        we_re_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] address_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] instruction_o,
  output logic        valid_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic [31:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [31:0]       instr_q, instr_d;

  logic              accept;
  logic              addr_mis;
  logic [ADDR_W-1:0] addr_idx;
  logic              unused_addr;

  assign addr_idx    = address_i[ADDR_W+1:2];
  assign unused_addr = ^{address_i[31:ADDR_W+2], address_i[1:0]};

`ifdef IMEM_MISALIGN_CHECK_EN
  assign addr_mis = |address_i[1:0];
`else
  assign addr_mis = 1'b0;
`endif

  // Reset gates acceptance so the array cannot be written while held in reset.
  assign accept = rst_ni && request_i && (state_q != StWait);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    mis_d   = mis_q;
    if (accept) begin
      idx_d = addr_idx;
      we_d  = we_re_i;
      mis_d = addr_mis;
    end
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatM1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      default: state_d = StIdle;
    endcase

    valid_d = (state_d == StResp);
    fault_d = valid_d && mis_d;
    // idx_d (not idx_q) so a LATENCY=1 read sees the address accepted this edge.
    instr_d = instr_q;
    if (valid_d && !we_d) instr_d = mis_d ? Nop : mem_q[idx_d];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
    end
  end

  // Array has no reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && we_re_i && !addr_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_i[b]) mem_q[addr_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign instruction_o = instr_q;
  assign valid_o       = valid_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_imem_controller.sv
// Bench for imem_controller: three instances (LATENCY 1, 3, 4) with separate
// input buses, compared every cycle against a transaction-level model that
// tracks when each instance is free, when its response is due and what the
// memory holds.

module tb_imem_controller;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  msk   [3];
  logic [31:0] adr   [3];
  logic [31:0] wd    [3];
  logic [31:0] instr [3];
  logic        vld   [3];
  logic        flt   [3];

  imem_controller #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .request_i(req[0]), .we_re_i(we[0]), .mask_i(msk[0]),
    .address_i(adr[0]), .wdata_i(wd[0]), .instruction_o(instr[0]), .valid_o(vld[0]),
    .fault_o(flt[0])
  );
  imem_controller #(.DEPTH(1024), .ADDR_W(10), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .request_i(req[1]), .we_re_i(we[1]), .mask_i(msk[1]),
    .address_i(adr[1]), .wdata_i(wd[1]), .instruction_o(instr[1]), .valid_o(vld[1]),
    .fault_o(flt[1])
  );
  imem_controller #(.DEPTH(1024), .ADDR_W(10), .LATENCY(4)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .request_i(req[2]), .we_re_i(we[2]), .mask_i(msk[2]),
    .address_i(adr[2]), .wdata_i(wd[2]), .instruction_o(instr[2]), .valid_o(vld[2]),
    .fault_o(flt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_m   [3][1024];
  int          n;
  int          free_at [3];
  bit          p_on    [3];
  int          p_due   [3];
  bit          p_read  [3];
  bit          p_fault [3];
  logic [31:0] p_data  [3];
  logic [31:0] exp_i   [3];
  bit          exp_v   [3];
  bit          exp_f   [3];

  int n_assert;
  int n_fail;

  function automatic int lat(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit misaligned(logic [31:0] a);
`ifdef IMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %h, expected %h", tag, k, obs, expv);
    end
  endtask

  // One clock edge: update the model from the sampled inputs, then compare.
  task automatic step();
    logic [31:0] w;
    int          idx;
    bit          mis;
    @(posedge clk);
    n++;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && req[k] && n >= free_at[k]) begin
        mis = misaligned(adr[k]);
        idx = int'(adr[k][11:2]);
        if (we[k]) begin
          if (!mis) begin
            w = mem_m[k][idx];
            for (int b = 0; b < 4; b++) if (msk[k][b]) w[8*b +: 8] = wd[k][8*b +: 8];
            mem_m[k][idx] = w;
          end
          p_read[k] = 1'b0;
        end else begin
          p_read[k] = 1'b1;
          p_data[k] = mis ? Nop : mem_m[k][idx];
        end
        p_fault[k] = mis;
        p_on[k]    = 1'b1;
        p_due[k]   = n + lat(k) - 1;
        free_at[k] = n + lat(k);
      end
      exp_v[k] = 1'b0;
      exp_f[k] = 1'b0;
      if (p_on[k] && p_due[k] == n) begin
        exp_v[k] = 1'b1;
        exp_f[k] = p_fault[k];
        if (p_read[k]) exp_i[k] = p_data[k];
        p_on[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check("valid", k, {31'b0, vld[k]}, {31'b0, exp_v[k]});
      check("fault", k, {31'b0, flt[k]}, {31'b0, exp_f[k]});
      check("instruction", k, instr[k], exp_i[k]);
    end
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      p_on[k]    = 1'b0;
      free_at[k] = 0;
      exp_i[k]   = 32'h0;
    end
  endtask

  // Same transaction on all three instances, then enough idle edges for L=4.
  task automatic xact(bit w, logic [3:0] m, logic [31:0] a, logic [31:0] d);
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b1; we[k] = w; msk[k] = m; adr[k] = a; wd[k] = d;
    end
    step();
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    idle(4);
  endtask

  initial begin
    logic [31:0] a;
    n = 0; n_assert = 0; n_fail = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b1; we[k] = 1'b1; msk[k] = 4'h0; adr[k] = 32'h0; wd[k] = 32'hFFFF_FFFF;
    end

    // Reset held with request asserted: nothing may respond.
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(6);  // mask=0 writes: no array change, still respond
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    idle(4);

    // Preload words 0..15.
    for (int i = 0; i < 16; i++) xact(1'b1, 4'hF, 32'(i * 4), $urandom());
    xact(1'b1, 4'hF, 32'h0, 32'd11);
    xact(1'b1, 4'hF, 32'h4, 32'd22);
    xact(1'b1, 4'hF, 32'h8, 32'd33);
    xact(1'b1, 4'hF, 32'hC, 32'd44);
    xact(1'b1, 4'hF, 32'h14, 32'hAABB_CCDD);

    // LATENCY=1 streaming: one word per cycle.
    req[0] = 1'b1; we[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adr[0] = 32'(i * 4);
      step();
    end
    req[0] = 1'b0;
    idle(4);

    // LATENCY=3 single read, request toggled during the wait.
    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h8;
    step();
    req[1] = 1'b0;
    step();
    req[1] = 1'b1; adr[1] = 32'h0;
    step();
    req[1] = 1'b0;
    idle(4);
    check("l3_read", 1, instr[1], 32'd33);

    // Byte-lane write and readback.
    xact(1'b1, 4'b0101, 32'h14, 32'h1122_3344);
    xact(1'b0, 4'h0, 32'h14, 32'h0);
    for (int k = 0; k < 3; k++) check("byte_lane", k, instr[k], 32'hAA22_CC44);

    // Address wrap modulo DEPTH*4.
    xact(1'b1, 4'hF, 32'h0, 32'h1234);
    xact(1'b0, 4'h0, 32'h1000, 32'h0);
    for (int k = 0; k < 3; k++) check("wrap", k, instr[k], 32'h1234);

    // Write on L=4, reset after its 2nd edge: response dropped, write kept.
    req[2] = 1'b1; we[2] = 1'b1; msk[2] = 4'hF; adr[2] = 32'h24; wd[2] = 32'hDEAD_BEEF;
    step();
    req[2] = 1'b0;
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_valid", k, {31'b0, vld[k]}, 32'h0);
      check("rst_instr", k, instr[k], 32'h0);
    end
    idle(2);
    rst_n = 1'b1;
    idle(6);
    req[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h24;
    step();
    req[2] = 1'b0;
    idle(4);
    check("persist", 2, instr[2], 32'hDEAD_BEEF);

    // Misaligned read.
    xact(1'b0, 4'h0, 32'h6, 32'h0);
`ifdef IMEM_MISALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) check("misalign_nop", k, instr[k], Nop);
`else
    for (int k = 0; k < 3; k++) check("misalign_aligned", k, instr[k], 32'd22);
`endif

    // Free-running random traffic, independent per instance.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        a = {$urandom(), 12'h0} | {26'h0, 6'($urandom_range(0, 63))};
        req[k] = ($urandom_range(0, 2) != 0);
        we[k]  = ($urandom_range(0, 3) == 0);
        msk[k] = 4'($urandom());
        adr[k] = a;
        wd[k]  = $urandom();
      end
      step();
    end
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
